pipe_hazard_ctrl: RTL and testbench

Central sequencer for the five-stage pipeline. It generates the write-enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches and jumps, and multi-cycle data-memory accesses. It sits beside the pipeline registers and drives their `*_WR` inputs and bubble/flush controls from ID-, EX- and MEM-stage status.

---
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard sequencer for the five-stage pipeline: decodes stage write enables and
// bubble flushes from ID/EX/MEM status, and tracks data-memory stalls.
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_memr,
    input  logic [4:0]       ex_rd,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             mem_branch_taken,
    input  logic             clr_cnt,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             id_ex_wr,
    output logic             ex_mem_wr,
    output logic             mem_wb_wr,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic             state
);

    typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX_V = WCNT_W'(WAIT_MAX);
    localparam logic [WCNT_W-1:0] WAIT_M1_V  = WCNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  CNT_ONES   = {CNT_W{1'b1}};

    state_t            r_state;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_timeout;

    logic       w_load_use;
    logic       w_miss;
    logic [4:0] w_wr;
    logic [2:0] w_fl;
    logic       w_wait_inc;
    logic       w_branch;
    state_t     w_next;

    assign w_load_use = ex_memr && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign w_miss     = mem_req && !mem_ready;

    // Priority decode of enables/flushes; everything held low while in reset.
    always_comb begin
        w_wr       = 5'b00000;
        w_fl       = 3'b000;
        w_wait_inc = 1'b0;
        w_branch   = 1'b0;
        w_next     = r_state;
        if (!rst) begin
            w_next = ST_RUN;
        end else if ((r_state == ST_WAIT) && !mem_ready) begin
            w_wait_inc = 1'b1;
        end else if ((r_state == ST_RUN) && w_miss) begin
            w_wait_inc = 1'b1;
            w_next     = ST_WAIT;
        end else begin
            w_next = ST_RUN;
            if (mem_branch_taken) begin
                w_wr     = 5'b11111;
                w_fl     = 3'b111;
                w_branch = 1'b1;
            end else if (w_load_use) begin
                // The load reaches MEM next cycle, so one bubble suffices.
                w_wr = 5'b00111;
                w_fl = 3'b010;
            end else if (id_jump) begin
                w_wr = 5'b11111;
                w_fl = 3'b100;
            end else begin
                w_wr = 5'b11111;
            end
        end
    end

    // FSM state, wait counter, sticky timeout and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= {WCNT_W{1'b0}};
            r_stall_cnt <= {CNT_W{1'b0}};
            r_flush_cnt <= {CNT_W{1'b0}};
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (!w_wait_inc) begin
                r_wait_cnt <= {WCNT_W{1'b0}};
            end else if (r_wait_cnt < WAIT_MAX_V) begin
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end else begin
                r_wait_cnt <= r_wait_cnt;
            end

            if (clr_cnt) begin
                r_timeout <= 1'b0;
            end else if (w_wait_inc && (r_wait_cnt >= WAIT_M1_V)) begin
                r_timeout <= 1'b1;
            end else begin
                r_timeout <= r_timeout;
            end

            if (clr_cnt) begin
                r_stall_cnt <= {CNT_W{1'b0}};
            end else if (!w_wr[4] && (r_stall_cnt != CNT_ONES)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end

            if (clr_cnt) begin
                r_flush_cnt <= {CNT_W{1'b0}};
            end else if (w_branch && (r_flush_cnt != CNT_ONES)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign pc_wr        = w_wr[4];
    assign if_id_wr     = w_wr[3];
    assign id_ex_wr     = w_wr[2];
    assign ex_mem_wr    = w_wr[1];
    assign mem_wb_wr    = w_wr[0];
    assign if_id_flush  = w_fl[2];
    assign id_ex_flush  = w_fl[1];
    assign ex_mem_flush = w_fl[0];
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign mem_timeout  = r_timeout;
    assign state        = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with WAIT_MAX=4 and 8-bit counters.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rt, id_jump, ex_memr, mem_req, mem_ready, mem_branch_taken, clr_cnt;
    logic       pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
    logic       if_id_flush, id_ex_flush, ex_mem_flush;
    logic [7:0] stall_cnt, flush_cnt;
    logic       mem_timeout, state;
    logic [7:0] ctl;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.WAIT_MAX(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .ex_memr(ex_memr), .ex_rd(ex_rd), .mem_req(mem_req),
        .mem_ready(mem_ready), .mem_branch_taken(mem_branch_taken), .clr_cnt(clr_cnt),
        .pc_wr(pc_wr), .if_id_wr(if_id_wr), .id_ex_wr(id_ex_wr), .ex_mem_wr(ex_mem_wr),
        .mem_wb_wr(mem_wb_wr), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    assign ctl = {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
                  if_id_flush, id_ex_flush, ex_mem_flush};

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rt = 1'b0; id_jump = 1'b0; ex_memr = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1; mem_branch_taken = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        id_rs = 5'd5; id_rt = 5'd5; ex_rd = 5'd5; id_uses_rt = 1'b1; id_jump = 1'b1;
        ex_memr = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; mem_branch_taken = 1'b1; clr_cnt = 1'b0;
        #12;
        checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 8'h00); end
        checks++; if (state !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", state); end
        checks++; if ({stall_cnt, flush_cnt, mem_timeout} !== 17'd0)
            begin errors++; $display("FAIL reset_cnt got %h %h %b exp 0", stall_cnt, flush_cnt, mem_timeout); end
        #1;
        idle();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 8'b11111_000) begin errors++; $display("FAIL release_run got %b exp 11111000", ctl); end
        next_cycle();
    endtask

    task automatic test_load_use();
        idle(); ex_memr = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        @(negedge clk);
        checks++; if (ctl !== 8'b00111_010) begin errors++; $display("FAIL lu_rs got %b exp 00111010", ctl); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL lu_cnt0 got %0d exp 0", stall_cnt); end
        next_cycle();
        idle(); ex_memr = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        @(negedge clk);
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL lu_cnt1 got %0d exp 1", stall_cnt); end
        checks++; if (ctl !== 8'b11111_000) begin errors++; $display("FAIL lu_r0 got %b exp 11111000", ctl); end
        next_cycle();
        idle(); ex_memr = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 8'b00111_010) begin errors++; $display("FAIL lu_rt got %b exp 00111010", ctl); end
        next_cycle();
        id_uses_rt = 1'b0;
        @(negedge clk);
        checks++; if (ctl !== 8'b11111_000) begin errors++; $display("FAIL lu_rt_unused got %b exp 11111000", ctl); end
        checks++; if (stall_cnt !== 8'd2) begin errors++; $display("FAIL lu_cnt2 got %0d exp 2", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_jump();
        idle(); id_jump = 1'b1;
        @(negedge clk);
        checks++; if (ctl !== 8'b11111_100) begin errors++; $display("FAIL jump got %b exp 11111100", ctl); end
        next_cycle();
        ex_memr = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        @(negedge clk);
        checks++; if (ctl !== 8'b00111_010) begin errors++; $display("FAIL jump_lu got %b exp 00111010", ctl); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL jump_cnt got %0d exp 3", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_branch_load_use();
        idle(); mem_branch_taken = 1'b1; ex_memr = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        @(negedge clk);
        checks++; if (ctl !== 8'b11111_111) begin errors++; $display("FAIL br_lu got %b exp 11111111", ctl); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (flush_cnt !== 8'd1) begin errors++; $display("FAIL br_fcnt got %0d exp 1", flush_cnt); end
        checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL br_scnt got %0d exp 3", stall_cnt); end
        next_cycle();
    endtask

    task automatic test_mem_wait();
        idle(); mem_req = 1'b1; mem_ready = 1'b0; mem_branch_taken = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL wait_ctl%0d got %b exp 0", k, ctl); end
            checks++; if (state !== (k >= 2)) begin errors++; $display("FAIL wait_state%0d got %b exp %b", k, state, k >= 2); end
            next_cycle();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++; if (state !== 1'b1) begin errors++; $display("FAIL wait_st3 got %b exp 1", state); end
        checks++; if (ctl !== 8'b11111_111) begin errors++; $display("FAIL wait_release got %b exp 11111111", ctl); end
        checks++; if (stall_cnt !== 8'd6) begin errors++; $display("FAIL wait_scnt got %0d exp 6", stall_cnt); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if (state !== 1'b0) begin errors++; $display("FAIL wait_run got %b exp 0", state); end
        checks++; if (flush_cnt !== 8'd2) begin errors++; $display("FAIL wait_fcnt got %0d exp 2", flush_cnt); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL wait_noto got %b exp 0", mem_timeout); end
        next_cycle();
    endtask

    task automatic test_timeout();
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++; if (mem_timeout !== (k >= 5)) begin errors++; $display("FAIL to_flag%0d got %b exp %b", k, mem_timeout, k >= 5); end
            checks++; if (state !== (k >= 2)) begin errors++; $display("FAIL to_state%0d got %b exp %b", k, state, k >= 2); end
            next_cycle();
        end
        clr_cnt = 1'b1;
        @(negedge clk);
        checks++; if (stall_cnt !== 8'd12) begin errors++; $display("FAIL to_scnt got %0d exp 12", stall_cnt); end
        next_cycle();
        clr_cnt = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({stall_cnt, flush_cnt, mem_timeout} !== 17'd0)
            begin errors++; $display("FAIL to_clear got %h %h %b exp 0", stall_cnt, flush_cnt, mem_timeout); end
        checks++; if (state !== 1'b1) begin errors++; $display("FAIL to_still_wait got %b exp 1", state); end
        checks++; if (ctl !== 8'b11111_000) begin errors++; $display("FAIL to_release got %b exp 11111000", ctl); end
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if ({state, stall_cnt, mem_timeout} !== 10'd0)
            begin errors++; $display("FAIL to_after got %b %0d %b exp 0", state, stall_cnt, mem_timeout); end
        next_cycle();
    endtask

    task automatic test_saturate();
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        repeat (260) next_cycle();
        @(negedge clk);
        checks++; if (stall_cnt !== 8'hFF) begin errors++; $display("FAIL sat_scnt got %h exp ff", stall_cnt); end
        next_cycle();
        idle(); clr_cnt = 1'b1;
        next_cycle();
        idle();
        @(negedge clk);
        checks++; if ({state, stall_cnt, mem_timeout} !== 10'd0)
            begin errors++; $display("FAIL sat_clear got %b %0d %b exp 0", state, stall_cnt, mem_timeout); end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        idle(); mem_req = 1'b1; mem_ready = 1'b0;
        next_cycle();
        checks++; if (state !== 1'b1) begin errors++; $display("FAIL rmw_wait got %b exp 1", state); end
        rst = 1'b0;
        #1;
        checks++; if (state !== 1'b0) begin errors++; $display("FAIL rmw_state got %b exp 0", state); end
        checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL rmw_ctl got %b exp 0", ctl); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL rmw_scnt got %0d exp 0", stall_cnt); end
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        checks++; if ({state, ctl} !== 9'b0_11111_000) begin errors++; $display("FAIL rmw_run got %b %b exp 0 11111000", state, ctl); end
        next_cycle();
        @(negedge clk);
        checks++; if ({state, stall_cnt} !== 9'd0) begin errors++; $display("FAIL rmw_after got %b %0d exp 0", state, stall_cnt); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_jump();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_saturate();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
